// File: rtl/piano_voice_scheduler.sv
// piano_voice_scheduler: shares one square-wave tone generator among 12 keys.
// Synchronises and debounces the key vector, picks a note (priority or
// arpeggio) and emits its half-period with a reload strobe.
// Optional build macro: PIANO_LAST_NOTE_PRIO_EN (mode 0 plays the most
// recently pressed key instead of the lowest one).
module piano_voice_scheduler #(
  parameter int DEBOUNCE_CYC = 5000,
  parameter int ARP_STEP_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [11:0] keys_in,
  input  logic [2:0]  octave_in,
  input  logic        mode_in,
  output logic        note_valid,
  output logic [3:0]  note_idx,
  output logic [14:0] half_period,
  output logic        note_strobe
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int AS_W = $clog2(ARP_STEP_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [AS_W-1:0] AS_LAST = AS_W'(ARP_STEP_CYC - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  logic [11:0]     keys_s1_q, keys_s1_d, keys_s2_q, keys_s2_d;
  logic [11:0]     keys_db_q, keys_db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
  logic            mode_prev_q, mode_prev_d;
  logic [2:0]      octave_q, octave_d;
  state_t          state_q, state_d;
  logic [AS_W-1:0] step_q, step_d;
  logic            note_valid_q, note_valid_d;
  logic [3:0]      note_idx_q, note_idx_d;
  logic [14:0]     half_period_q, half_period_d;
  logic            note_strobe_q, note_strobe_d;
  logic            new_note, arp_step;
  logic [3:0]      sel_idx;
`ifdef PIANO_LAST_NOTE_PRIO_EN
  logic [11:0]     keys_db_prev_q, keys_db_prev_d;
  logic [11:0]     new_bits;
`endif

  // Octave-0 half-period table at 1 MHz.
  function automatic logic [14:0] base_period(input logic [3:0] idx);
    case (idx)
      4'd0:    base_period = 15'd30577;
      4'd1:    base_period = 15'd28862;
      4'd2:    base_period = 15'd27242;
      4'd3:    base_period = 15'd25714;
      4'd4:    base_period = 15'd24270;
      4'd5:    base_period = 15'd22907;
      4'd6:    base_period = 15'd21622;
      4'd7:    base_period = 15'd20408;
      4'd8:    base_period = 15'd19263;
      4'd9:    base_period = 15'd18182;
      4'd10:   base_period = 15'd17161;
      4'd11:   base_period = 15'd16198;
      default: base_period = 15'd0;
    endcase
  endfunction

  function automatic logic [3:0] lowest_idx(input logic [11:0] v);
    lowest_idx = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

  // Next held key above cur, wrapping around to the lowest held key.
  function automatic logic [3:0] next_idx(input logic [11:0] v, input logic [3:0] cur);
    logic found;
    next_idx = lowest_idx(v);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!found && (4'(i) > cur) && v[i]) begin
        next_idx = 4'(i);
        found = 1'b1;
      end
    end
  endfunction

  // Synchronisers and whole-vector debounce; a change entering the second sync stage restarts the count.
  always_comb begin
    keys_s1_d   = keys_in;
    keys_s2_d   = keys_s1_q;
    mode_s1_d   = mode_in;
    mode_s2_d   = mode_s1_q;
    mode_prev_d = mode_s2_q;
    octave_d    = octave_in;
    keys_db_d   = keys_db_q;
    db_cnt_d    = db_cnt_q;
`ifdef PIANO_LAST_NOTE_PRIO_EN
    keys_db_prev_d = keys_db_q;
`endif
    if (keys_s1_q != keys_s2_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      keys_db_d = keys_s2_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Note selection, arpeggio FSM and strobe generation.
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    note_valid_d  = note_valid_q;
    note_idx_d    = note_idx_q;
    half_period_d = half_period_q;
    note_strobe_d = 1'b0;
    new_note      = 1'b0;
    arp_step      = 1'b0;
    sel_idx       = note_idx_q;
`ifdef PIANO_LAST_NOTE_PRIO_EN
    new_bits      = keys_db_q & ~keys_db_prev_q;
`endif
    if (mode_s2_q != mode_prev_q) begin
      state_d = IDLE;
      step_d  = '0;
    end else if (!mode_s2_q) begin
      state_d = IDLE;
      step_d  = '0;
      if (keys_db_q != 12'd0) begin
        new_note = 1'b1;
`ifdef PIANO_LAST_NOTE_PRIO_EN
        if (new_bits != 12'd0) sel_idx = lowest_idx(new_bits);
        else if (note_valid_q && keys_db_q[note_idx_q]) sel_idx = note_idx_q;
        else sel_idx = lowest_idx(keys_db_q);
`else
        sel_idx = lowest_idx(keys_db_q);
`endif
      end else begin
        note_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (keys_db_q != 12'd0) begin
            state_d  = PLAY;
            step_d   = '0;
            new_note = 1'b1;
            sel_idx  = lowest_idx(keys_db_q);
          end else begin
            note_valid_d = 1'b0;
          end
        end
        PLAY: begin
          if (keys_db_q == 12'd0) begin
            state_d      = IDLE;
            step_d       = '0;
            note_valid_d = 1'b0;
          end else if ((step_q == AS_LAST) || !keys_db_q[note_idx_q]) begin
            step_d   = '0;
            new_note = 1'b1;
            arp_step = 1'b1;
            sel_idx  = next_idx(keys_db_q, note_idx_q);
          end else begin
            step_d   = step_q + AS_W'(1);
            new_note = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (new_note) begin
      note_valid_d  = 1'b1;
      note_idx_d    = sel_idx;
      half_period_d = base_period(sel_idx) >> octave_q;
      note_strobe_d = arp_step || !note_valid_q || (sel_idx != note_idx_q) ||
                      (half_period_d != half_period_q);
    end
  end

  // State registers: async reset, synchronous clear while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !ena) begin
      keys_s1_q     <= '0;
      keys_s2_q     <= '0;
      keys_db_q     <= '0;
      db_cnt_q      <= '0;
      mode_s1_q     <= 1'b0;
      mode_s2_q     <= 1'b0;
      mode_prev_q   <= 1'b0;
      octave_q      <= '0;
      state_q       <= IDLE;
      step_q        <= '0;
      note_valid_q  <= 1'b0;
      note_idx_q    <= '0;
      half_period_q <= '0;
      note_strobe_q <= 1'b0;
`ifdef PIANO_LAST_NOTE_PRIO_EN
      keys_db_prev_q <= '0;
`endif
    end else begin
      keys_s1_q     <= keys_s1_d;
      keys_s2_q     <= keys_s2_d;
      keys_db_q     <= keys_db_d;
      db_cnt_q      <= db_cnt_d;
      mode_s1_q     <= mode_s1_d;
      mode_s2_q     <= mode_s2_d;
      mode_prev_q   <= mode_prev_d;
      octave_q      <= octave_d;
      state_q       <= state_d;
      step_q        <= step_d;
      note_valid_q  <= note_valid_d;
      note_idx_q    <= note_idx_d;
      half_period_q <= half_period_d;
      note_strobe_q <= note_strobe_d;
`ifdef PIANO_LAST_NOTE_PRIO_EN
      keys_db_prev_q <= keys_db_prev_d;
`endif
    end
  end

  assign note_valid  = note_valid_q;
  assign note_idx    = note_idx_q;
  assign half_period = half_period_q;
  assign note_strobe = note_strobe_q;

endmodule

// File: tb/tb_piano_voice_scheduler.sv
// Directed bench for piano_voice_scheduler with DEBOUNCE_CYC=4, ARP_STEP_CYC=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Key-to-output latency: 2 sync edges + 4 debounce edges + 1 output edge = 7 edges.
module tb_piano_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [11:0] keys_in = 12'd0;
  logic [2:0]  octave_in = 3'd0;
  logic        mode_in = 1'b0;
  logic        note_valid;
  logic [3:0]  note_idx;
  logic [14:0] half_period;
  logic        note_strobe;

  int cmp_cnt = 0;
  int fail_cnt = 0;
  int strobe_cnt = 0;
  int s0;

  piano_voice_scheduler #(
    .DEBOUNCE_CYC(4),
    .ARP_STEP_CYC(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .keys_in(keys_in),
    .octave_in(octave_in),
    .mode_in(mode_in),
    .note_valid(note_valid),
    .note_idx(note_idx),
    .half_period(half_period),
    .note_strobe(note_strobe)
  );

  always #5 clk = ~clk;

  // Count strobe pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (note_strobe === 1'b1) strobe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] k, input logic [2:0] o, input logic m);
    keys_in   = k;
    octave_in = o;
    mode_in   = m;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    cmp_cnt++;
    assert (observed === expected)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset, then idle with no keys.
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(100);
    checkOutput("rst_valid", int'(note_valid), 0);
    checkOutput("rst_idx", int'(note_idx), 0);
    checkOutput("rst_hp", int'(half_period), 0);
    checkOutput("rst_strobes", strobe_cnt, 0);

    // Single key E, octave 2: 24270 >> 2 = 6067.
    $display("[TB] single key priority");
    s0 = strobe_cnt;
    applyStimulus(12'h010, 3'd2, 1'b0);
    tick(6);
    checkOutput("k4_early_valid", int'(note_valid), 0);
    tick(1);
    checkOutput("k4_valid", int'(note_valid), 1);
    checkOutput("k4_idx", int'(note_idx), 4);
    checkOutput("k4_hp", int'(half_period), 6067);
    tick(3);
    checkOutput("k4_strobes", strobe_cnt - s0, 1);

    // Release: note_valid falls, index and period hold, no strobe.
    s0 = strobe_cnt;
    applyStimulus(12'h000, 3'd2, 1'b0);
    tick(7);
    checkOutput("rel_valid", int'(note_valid), 0);
    checkOutput("rel_idx_hold", int'(note_idx), 4);
    checkOutput("rel_hp_hold", int'(half_period), 6067);
    tick(2);
    checkOutput("rel_strobes", strobe_cnt - s0, 0);

    // Bouncing key never settles long enough to be accepted.
    $display("[TB] bounce rejection");
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) begin
      keys_in = keys_in ^ 12'h010;
      tick(2);
    end
    checkOutput("bounce_valid", int'(note_valid), 0);
    applyStimulus(12'h010, 3'd2, 1'b0);
    tick(6);
    checkOutput("settle_early_valid", int'(note_valid), 0);
    tick(1);
    checkOutput("settle_valid", int'(note_valid), 1);
    checkOutput("settle_idx", int'(note_idx), 4);
    tick(2);
    checkOutput("settle_strobes", strobe_cnt - s0, 1);

    // Add key 7 while 4 is held, then release 4: 20408 >> 2 = 5102.
    $display("[TB] two keys, priority");
    s0 = strobe_cnt;
    applyStimulus(12'h090, 3'd2, 1'b0);
    tick(7);
`ifdef PIANO_LAST_NOTE_PRIO_EN
    checkOutput("k47_idx", int'(note_idx), 7);
`else
    checkOutput("k47_idx", int'(note_idx), 4);
`endif
    checkOutput("k47_valid", int'(note_valid), 1);
    applyStimulus(12'h080, 3'd2, 1'b0);
    tick(7);
    checkOutput("k7_idx", int'(note_idx), 7);
    checkOutput("k7_hp", int'(half_period), 5102);
`ifdef PIANO_LAST_NOTE_PRIO_EN
    checkOutput("k7_strobe", int'(note_strobe), 0);
`else
    checkOutput("k7_strobe", int'(note_strobe), 1);
`endif
    tick(2);
    checkOutput("k47_strobes", strobe_cnt - s0, 1);

    // Switch to arpeggio mode with no keys held.
    applyStimulus(12'h000, 3'd0, 1'b1);
    tick(12);
    checkOutput("arp_idle_valid", int'(note_valid), 0);

    // Arpeggio over keys 0, 4, 11 at octave 0, 16 cycles each.
    $display("[TB] arpeggio");
    s0 = strobe_cnt;
    applyStimulus(12'h811, 3'd0, 1'b1);
    tick(7);
    checkOutput("arp0_valid", int'(note_valid), 1);
    checkOutput("arp0_idx", int'(note_idx), 0);
    checkOutput("arp0_hp", int'(half_period), 30577);
    checkOutput("arp0_strobe", int'(note_strobe), 1);
    tick(15);
    checkOutput("arp0_hold_idx", int'(note_idx), 0);
    checkOutput("arp0_hold_strobe", int'(note_strobe), 0);
    tick(1);
    checkOutput("arp1_idx", int'(note_idx), 4);
    checkOutput("arp1_hp", int'(half_period), 24270);
    checkOutput("arp1_strobe", int'(note_strobe), 1);
    tick(15);
    checkOutput("arp1_hold_idx", int'(note_idx), 4);
    tick(1);
    checkOutput("arp2_idx", int'(note_idx), 11);
    checkOutput("arp2_hp", int'(half_period), 16198);
    tick(16);
    checkOutput("arp3_idx", int'(note_idx), 0);
    checkOutput("arp3_hp", int'(half_period), 30577);
    checkOutput("arp3_strobe", int'(note_strobe), 1);

    // Release all during the arpeggio.
    applyStimulus(12'h000, 3'd0, 1'b1);
    tick(6);
    checkOutput("arp_rel_early_valid", int'(note_valid), 1);
    tick(1);
    checkOutput("arp_rel_valid", int'(note_valid), 0);
    checkOutput("arp_rel_strobe", int'(note_strobe), 0);
    tick(2);
    checkOutput("arp_strobes", strobe_cnt - s0, 4);

    // Single key 9 in arpeggio, octave change 0 -> 3: 18182 >> 3 = 2272.
    $display("[TB] octave change and single-key replay");
    applyStimulus(12'h200, 3'd0, 1'b1);
    tick(7);
    checkOutput("k9_idx", int'(note_idx), 9);
    checkOutput("k9_hp", int'(half_period), 18182);
    tick(1);
    octave_in = 3'd3;
    tick(1);
    checkOutput("oct_before_hp", int'(half_period), 18182);
    tick(1);
    checkOutput("oct_after_hp", int'(half_period), 2272);
    checkOutput("oct_strobe", int'(note_strobe), 1);
    tick(12);
    checkOutput("replay_pre_strobe", int'(note_strobe), 0);
    tick(1);
    checkOutput("replay_strobe", int'(note_strobe), 1);
    checkOutput("replay_idx", int'(note_idx), 9);
    checkOutput("replay_hp", int'(half_period), 2272);

    // Asynchronous reset mid-arpeggio, between clock edges.
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", int'(note_valid), 0);
    checkOutput("async_rst_idx", int'(note_idx), 0);
    checkOutput("async_rst_hp", int'(half_period), 0);
    checkOutput("async_rst_strobe", int'(note_strobe), 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
